// File: rtl/trees_dma_chunked_ctrl_pkg.sv
// Shared types and width-derived constants for the chunked tree-ensemble DMA front-end.
package trees_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_COMPUTE,
    S_WR_REQ,
    S_WR_DATA,
    S_NEXT,
    S_DONE
  } state_e;

  localparam logic [63:0] SIGNATURE_64 = 64'h524F445249474F2E;
  localparam logic [31:0] SIGNATURE_32 = 32'h4749524F;

  function automatic int unsigned fpb(input int unsigned dw);
    return dw / 32;
  endfunction

  function automatic int unsigned ppb(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned tree_bts(input int unsigned dw, input int unsigned nt,
                                           input int unsigned nn);
    return nt * nn * 64 / dw;
  endfunction

  function automatic logic [2:0] dsize(input int unsigned dw);
    return (dw == 64) ? 3'b011 : 3'b010;
  endfunction

  function automatic logic [63:0] signature(input int unsigned dw);
    return (dw == 32) ? {32'h0, SIGNATURE_32} : SIGNATURE_64;
  endfunction

endpackage

// File: rtl/trees_dma_chunked_ctrl_len_calc.sv
// Combinational chunk geometry: samples in the chunk, DMA indices/lengths, and whether more chunks follow.
module trees_dma_len_calc
  import trees_dma_pkg::*;
#(
  parameter int unsigned DMA_WIDTH        = 64,
  parameter int unsigned N_TREES          = 128,
  parameter int unsigned N_NODE_AND_LEAFS = 256,
  parameter int unsigned N_FEATURE        = 32,
  parameter int unsigned CHUNK_LEN        = 512
) (
  input  logic        load_trees_i,
  input  logic [31:0] chunk_i,
  input  logic [31:0] burst_len_i,
  input  logic [31:0] rd_offset_i,
  input  logic [31:0] wr_offset_i,
  output logic [31:0] n_samples_o,
  output logic [31:0] rd_index_o,
  output logic [31:0] rd_length_o,
  output logic [31:0] wr_index_o,
  output logic [31:0] wr_length_o,
  output logic        more_o
);

  localparam logic [31:0] CHUNK     = 32'(CHUNK_LEN);
  localparam logic [31:0] FEAT      = 32'(N_FEATURE);
  localparam logic [31:0] FPB_C     = 32'(fpb(DMA_WIDTH));
  localparam logic [31:0] PPB_C     = 32'(ppb(DMA_WIDTH));
  localparam logic [31:0] RD_STRIDE = 32'(CHUNK_LEN * N_FEATURE / fpb(DMA_WIDTH));
  localparam logic [31:0] WR_STRIDE = 32'(CHUNK_LEN / ppb(DMA_WIDTH));
  localparam logic [31:0] TREE_LEN  = 32'(tree_bts(DMA_WIDTH, N_TREES, N_NODE_AND_LEAFS));

  logic [31:0] base;
  logic [31:0] remaining;
  logic [31:0] n;

  always_comb begin
    base      = chunk_i * CHUNK;
    remaining = burst_len_i - base;
    n         = (remaining < CHUNK) ? remaining : CHUNK;
  end

  assign n_samples_o = n;
  // Tree loading is a single transfer, so it never advances by chunk.
  assign rd_index_o  = load_trees_i ? rd_offset_i : rd_offset_i + chunk_i * RD_STRIDE;
  assign rd_length_o = load_trees_i ? TREE_LEN : (n * FEAT + FPB_C - 32'd1) / FPB_C;
  assign wr_index_o  = load_trees_i ? wr_offset_i : wr_offset_i + chunk_i * WR_STRIDE;
  assign wr_length_o = load_trees_i ? 32'd1 : (n + PPB_C - 32'd1) / PPB_C;
  assign more_o      = !load_trees_i && ((base + CHUNK) < burst_len_i);

endmodule

// File: rtl/trees_dma_chunked_ctrl.sv
// DMA front-end that splits an inference burst into read/compute/write chunks, or streams the model in tree-load mode.
module trees_dma_chunked_ctrl
  import trees_dma_pkg::*;
#(
  parameter int unsigned DMA_WIDTH        = 64,
  parameter int unsigned N_TREES          = 128,
  parameter int unsigned N_NODE_AND_LEAFS = 256,
  parameter int unsigned N_FEATURE        = 32,
  parameter int unsigned CHUNK_LEN        = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          conf_info_load_trees,
  input  logic [31:0]          conf_info_burst_len,
  input  logic [31:0]          conf_info_rd_offset,
  input  logic [31:0]          conf_info_wr_offset,
  input  logic                 conf_done,
  output logic                 acc_done,
  input  logic                 dma_read_ctrl_ready,
  output logic                 dma_read_ctrl_valid,
  output logic [31:0]          dma_read_ctrl_data_index,
  output logic [31:0]          dma_read_ctrl_data_length,
  output logic [2:0]           dma_read_ctrl_data_size,
  output logic [5:0]           dma_read_ctrl_data_user,
  output logic                 dma_read_chnl_ready,
  input  logic                 dma_read_chnl_valid,
  input  logic [DMA_WIDTH-1:0] dma_read_chnl_data,
  input  logic                 dma_write_ctrl_ready,
  output logic                 dma_write_ctrl_valid,
  output logic [31:0]          dma_write_ctrl_data_index,
  output logic [31:0]          dma_write_ctrl_data_length,
  output logic [2:0]           dma_write_ctrl_data_size,
  output logic [5:0]           dma_write_ctrl_data_user,
  input  logic                 dma_write_chnl_ready,
  output logic                 dma_write_chnl_valid,
  output logic [DMA_WIDTH-1:0] dma_write_chnl_data,
  output logic                 core_load_trees,
  output logic                 core_load_features,
  output logic [31:0]          core_addr,
  output logic [DMA_WIDTH-1:0] core_wdata,
  output logic                 core_start,
  output logic [31:0]          core_n_samples,
  input  logic                 core_done,
  output logic [31:0]          core_pred_addr,
  input  logic [DMA_WIDTH-1:0] core_pred_data
);

  localparam logic [2:0]           DSIZE    = dsize(DMA_WIDTH);
  localparam logic [63:0]          SIG_FULL = signature(DMA_WIDTH);
  localparam logic [DMA_WIDTH-1:0] SIG      = SIG_FULL[DMA_WIDTH-1:0];

  state_e      state_q, state_d;
  logic        load_q, load_d;
  logic [31:0] burst_q, burst_d, rd_off_q, rd_off_d, wr_off_q, wr_off_d;
  logic [31:0] chunk_q, chunk_d, rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic        core_start_q, core_start_d, acc_done_q, acc_done_d;

  logic [31:0] n_samples, rd_index, rd_len, wr_index, wr_len;
  logic        more, rd_beat, rd_last, wr_beat, wr_last;
  logic        unused_load_bits;

  assign unused_load_bits = ^conf_info_load_trees[31:1];

  trees_dma_len_calc #(
    .DMA_WIDTH       (DMA_WIDTH),
    .N_TREES         (N_TREES),
    .N_NODE_AND_LEAFS(N_NODE_AND_LEAFS),
    .N_FEATURE       (N_FEATURE),
    .CHUNK_LEN       (CHUNK_LEN)
  ) u_len_calc (
    .load_trees_i(load_q),
    .chunk_i     (chunk_q),
    .burst_len_i (burst_q),
    .rd_offset_i (rd_off_q),
    .wr_offset_i (wr_off_q),
    .n_samples_o (n_samples),
    .rd_index_o  (rd_index),
    .rd_length_o (rd_len),
    .wr_index_o  (wr_index),
    .wr_length_o (wr_len),
    .more_o      (more)
  );

  // Read channel ready is held for the whole of RD_DATA, so valid alone marks a beat.
  assign rd_beat = (state_q == S_RD_DATA) && dma_read_chnl_valid;
  assign rd_last = rd_beat && (rd_ptr_q == rd_len - 32'd1);
  assign wr_beat = (state_q == S_WR_DATA) && dma_write_chnl_ready;
  assign wr_last = wr_beat && (wr_ptr_q == wr_len - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (conf_done)
                   state_d = (!conf_info_load_trees[0] && conf_info_burst_len == 32'd0) ? S_DONE : S_RD_REQ;
      S_RD_REQ:  if (dma_read_ctrl_ready) state_d = S_RD_DATA;
      S_RD_DATA: if (rd_last) state_d = load_q ? S_WR_REQ : S_COMPUTE;
      S_COMPUTE: if (core_done) state_d = S_WR_REQ;
      S_WR_REQ:  if (dma_write_ctrl_ready) state_d = S_WR_DATA;
      S_WR_DATA: if (wr_last) state_d = S_NEXT;
      S_NEXT:    state_d = more ? S_RD_REQ : S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dma_read_ctrl_valid        = 1'b0;
    dma_read_ctrl_data_index   = '0;
    dma_read_ctrl_data_length  = '0;
    dma_read_ctrl_data_size    = '0;
    dma_read_ctrl_data_user    = '0;
    dma_read_chnl_ready        = 1'b0;
    dma_write_ctrl_valid       = 1'b0;
    dma_write_ctrl_data_index  = '0;
    dma_write_ctrl_data_length = '0;
    dma_write_ctrl_data_size   = '0;
    dma_write_ctrl_data_user   = '0;
    dma_write_chnl_valid       = 1'b0;
    dma_write_chnl_data        = '0;
    core_load_trees            = 1'b0;
    core_load_features         = 1'b0;
    case (state_q)
      S_RD_REQ: begin
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = rd_index;
        dma_read_ctrl_data_length = rd_len;
        dma_read_ctrl_data_size   = DSIZE;
      end
      S_RD_DATA: begin
        dma_read_chnl_ready = 1'b1;
        core_load_trees     = load_q && dma_read_chnl_valid;
        core_load_features  = !load_q && dma_read_chnl_valid;
      end
      S_WR_REQ: begin
        dma_write_ctrl_valid       = 1'b1;
        dma_write_ctrl_data_index  = wr_index;
        dma_write_ctrl_data_length = wr_len;
        dma_write_ctrl_data_size   = DSIZE;
      end
      S_WR_DATA: begin
        dma_write_chnl_valid = (wr_ptr_q < wr_len);
        dma_write_chnl_data  = load_q ? SIG : core_pred_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_d       = load_q;
    burst_d      = burst_q;
    rd_off_d     = rd_off_q;
    wr_off_d     = wr_off_q;
    chunk_d      = chunk_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    core_start_d = rd_last && !load_q;
    acc_done_d   = (state_q == S_DONE);
    if (state_q == S_IDLE && conf_done) begin
      load_d   = conf_info_load_trees[0];
      burst_d  = conf_info_burst_len;
      rd_off_d = conf_info_rd_offset;
      wr_off_d = conf_info_wr_offset;
      chunk_d  = '0;
    end
    if (state_q == S_NEXT) chunk_d = chunk_q + 32'd1;
    if (rd_last)      rd_ptr_d = '0;
    else if (rd_beat) rd_ptr_d = rd_ptr_q + 32'd1;
    if (wr_last)      wr_ptr_d = '0;
    else if (wr_beat) wr_ptr_d = wr_ptr_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q       <= 1'b0;
      burst_q      <= '0;
      rd_off_q     <= '0;
      wr_off_q     <= '0;
      chunk_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      core_start_q <= 1'b0;
      acc_done_q   <= 1'b0;
    end else begin
      load_q       <= load_d;
      burst_q      <= burst_d;
      rd_off_q     <= rd_off_d;
      wr_off_q     <= wr_off_d;
      chunk_q      <= chunk_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      core_start_q <= core_start_d;
      acc_done_q   <= acc_done_d;
    end
  end

  assign acc_done       = acc_done_q;
  assign core_start     = core_start_q;
  assign core_addr      = rd_ptr_q;
  assign core_wdata     = dma_read_chnl_data;
  assign core_n_samples = n_samples;
  assign core_pred_addr = wr_ptr_q;

endmodule
